pm_fold_reduce_256: RTL and testbench



---
 rtl/pm_fold_reduce_256_if.sv | 21 ++
 rtl/pm_fold_reduce_256.sv | 79 +++++++
 tb/tb_pm_fold_reduce_256.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pm_fold_reduce_256_if.sv
// Bus between the Karatsuba multiplier product and the modular reduction stage.
interface pm_fold_reduce_256_if;
  logic         in_valid;
  logic [511:0] P_in;
  logic [255:0] R;
  logic         out_valid;

  modport master (
    output in_valid,
    output P_in,
    input  R,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  P_in,
    output R,
    output out_valid
  );
endinterface

// File: rtl/pm_fold_reduce_256.sv
// Pipelined reduction of a 512-bit product modulo p = 2^256 - C.
// Two folds (2^256 == C mod p) followed by one conditional subtraction.
// Five register stages, one result per cycle, no backpressure.
module pm_fold_reduce_256 #(
  parameter logic [255:0] C  = 256'h1000003D1,
  parameter int unsigned  CW = 33
) (
  input logic                  clock,
  input logic                  reset,
  pm_fold_reduce_256_if.slave  bus
);

  localparam int unsigned    HW    = 256 + CW;
  localparam int unsigned    T1W   = 257 + CW;
  localparam int unsigned    F2W   = 2 * CW + 1;
  localparam logic [CW-1:0]  CK    = C[CW-1:0];
  localparam logic [256:0]   P_MOD = {1'b1, 256'b0} - {1'b0, C};

  logic           s0_v, s1_v, s2_v, s3_v;
  logic [511:0]   s0_p;
  logic [HW-1:0]  s1_hc;
  logic [255:0]   s1_lo;
  logic [T1W-1:0] s2_t1;
  logic [256:0]   s3_t2;

  logic [HW-1:0]  hc_next;
  logic [T1W-1:0] t1_next;
  logic [CW:0]    t1_hi;
  logic [F2W-1:0] fold2;
  logic [256:0]   t2_next;
  logic           t2_ge_p;
  logic [255:0]   t2_minus_p;
  logic [255:0]   r_next;

  // Fold arithmetic between the pipeline registers.
  always_comb begin
    hc_next    = {{CW{1'b0}}, s0_p[511:256]} * {{256{1'b0}}, CK};
    t1_next    = {1'b0, s1_hc} + {{(CW + 1){1'b0}}, s1_lo};
    t1_hi      = s2_t1[T1W-1:256];
    fold2      = {{CW{1'b0}}, t1_hi} * {{(CW + 1){1'b0}}, CK};
    t2_next    = {1'b0, s2_t1[255:0]} + {{(256 - 2 * CW){1'b0}}, fold2};
    t2_ge_p    = (s3_t2 >= P_MOD);
    // T2 < 2p, so the true difference fits in 256 bits and the modulo-2^256
    // subtraction of the low halves is exact, including when T2[256] is set.
    t2_minus_p = s3_t2[255:0] - P_MOD[255:0];
    r_next     = t2_ge_p ? t2_minus_p : s3_t2[255:0];
  end

  // Data pipeline registers; validity is tracked separately so no reset needed.
  always_ff @(posedge clock) begin
    s0_p  <= bus.P_in;
    s1_hc <= hc_next;
    s1_lo <= s0_p[255:0];
    s2_t1 <= t1_next;
    s3_t2 <= t2_next;
  end

  // Stage valids and the output register; reset flushes every in-flight entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_v          <= 1'b0;
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s3_v          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.R         <= '0;
    end else begin
      s0_v          <= bus.in_valid;
      s1_v          <= s0_v;
      s2_v          <= s1_v;
      s3_v          <= s2_v;
      bus.out_valid <= s3_v;
      if (s3_v) begin
        bus.R <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_pm_fold_reduce_256.sv
// Directed testbench for pm_fold_reduce_256 (secp256k1 defaults).
module tb_pm_fold_reduce_256;

  localparam logic [255:0] C_K    = 256'h1000003D1;
  localparam logic [255:0] P_K    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] C2M1_K = 256'h1_000007A2_000E90A0;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  pm_fold_reduce_256_if bus ();

  pm_fold_reduce_256 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.P_in     = '0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.R !== 256'd0) begin
      errors++;
      $display("FAIL reset_R: got %h want 0", bus.R);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_latency_zero;
    logic exp_v;
    bus.in_valid = 1'b1;
    bus.P_in     = '0;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_v = (k == 4);
      checks++;
      if (bus.out_valid !== exp_v) begin
        errors++;
        $display("FAIL latency_valid_N+%0d: got %b want %b", k, bus.out_valid, exp_v);
      end
      if (k == 4) begin
        checks++;
        if (bus.R !== 256'd0) begin
          errors++;
          $display("FAIL latency_R: got %h want 0", bus.R);
        end
      end
    end
  endtask

  task automatic test_single(input string name, input logic [511:0] pin, input logic [255:0] exp_r);
    bus.in_valid = 1'b1;
    bus.P_in     = pin;
    step();
    bus.in_valid = 1'b0;
    bus.P_in     = '0;
    step();
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_valid: got %b want 0", name, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b want 1", name, bus.out_valid);
    end
    checks++;
    if (bus.R !== exp_r) begin
      errors++;
      $display("FAIL %s_R: got %h want %h", name, bus.R, exp_r);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_end: got %b want 0", name, bus.out_valid);
    end
  endtask

  task automatic test_boundaries;
    logic [511:0] two256;
    logic [511:0] p_ext;
    logic [511:0] q;
    logic [511:0] pin;
    logic [511:0] rem;
    two256 = 512'h1 << 256;
    p_ext  = {256'b0, P_K};
    test_single("two256", two256, C_K);
    test_single("p_exact", p_ext, 256'd0);
    test_single("p_minus_1", p_ext - 512'd1, P_K - 256'd1);
    test_single("all_ones", '1, C2M1_K);
    test_single("p_squared", p_ext * p_ext, 256'd0);
    // H*C just below 2^256 with L = 2^256-1 puts T2 in [2^256, 2^256 + C).
    q   = two256 / {256'b0, C_K};
    pin = (q << 256) | (two256 - 512'd1);
    rem = pin % p_ext;
    test_single("carry_window", pin, rem[255:0]);
  endtask

  task automatic test_back_to_back;
    logic [511:0] vin [6];
    logic         vv  [6];
    logic         ev  [6];
    logic [255:0] er  [6];
    vin[0] = 512'h1 << 256; vv[0] = 1'b1;
    vin[1] = 512'd5;        vv[1] = 1'b1;
    vin[2] = '1;            vv[2] = 1'b1;
    vin[3] = '0;            vv[3] = 1'b0;
    vin[4] = '0;            vv[4] = 1'b0;
    vin[5] = 512'd3;        vv[5] = 1'b1;
    ev[0] = 1'b1; er[0] = C_K;
    ev[1] = 1'b1; er[1] = 256'd5;
    ev[2] = 1'b1; er[2] = C2M1_K;
    ev[3] = 1'b0; er[3] = C2M1_K;
    ev[4] = 1'b0; er[4] = C2M1_K;
    ev[5] = 1'b1; er[5] = 256'd3;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        bus.in_valid = vv[i];
        bus.P_in     = vin[i];
      end else begin
        bus.in_valid = 1'b0;
        bus.P_in     = '0;
      end
      step();
      if (i >= 4) begin
        checks++;
        if (bus.out_valid !== ev[i-4]) begin
          errors++;
          $display("FAIL b2b_valid_%0d: got %b want %b", i - 4, bus.out_valid, ev[i-4]);
        end
        checks++;
        if (bus.R !== er[i-4]) begin
          errors++;
          $display("FAIL b2b_R_%0d: got %h want %h", i - 4, bus.R, er[i-4]);
        end
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid;
    bus.in_valid = 1'b1;
    bus.P_in     = 512'h1 << 256;
    step();
    bus.in_valid = 1'b0;
    bus.P_in     = '0;
    step();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.P_in     = 512'd5;
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.P_in     = '0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid_N+2: got %b want 0", bus.out_valid);
    end
    for (int k = 3; k <= 10; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_valid_N+%0d: got %b want 0", k, bus.out_valid);
      end
    end
    checks++;
    if (bus.R !== 256'd0) begin
      errors++;
      $display("FAIL rst_mid_R: got %h want 0", bus.R);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.P_in     = '0;
    test_reset();
    test_latency_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
